br_sync_fifo_prm: RTL and testbench
===================================

// Module: br_sync_fifo_prm
// PURPOSE
//  Parametrised single-clock FIFO in native RTL (inferred RAM, no vendor IP); next-generation
//  successor to the fixed 1024x40 LMAC pre-control FIFOs. Adds almost-full/almost-empty
//  thresholds, a selectable first-word-fall-through (FWFT) read mode and optional error
//  counters. Buffers control/descriptor words between LMAC core stages in one clock domain.
// PARAMETERS
//  WIDTH   40    data word width, bits
//  PTR     10    address width; DEPTH must equal 2**PTR
//  DEPTH   1024  capacity, words (power of two, >=4)
//  AF_LVL  1020  almost_full asserted when usedw >= AF_LVL (1..DEPTH)
//  AE_LVL  4     almost_empty asserted when usedw <= AE_LVL (0..DEPTH-1)
//  FWFT    0     0 = standard read (q 1 cycle after rdreq); 1 = first-word-fall-through
// PORTS
//  clk           in   1        single clock, all logic on rising edge
//  srst          in   1        synchronous reset, active-high
//  wrreq         in   1        write request
//  data          in   WIDTH    write data
//  full          out  1        usedw == DEPTH
//  almost_full   out  1        usedw >= AF_LVL
//  rdreq         in   1        read request (FWFT: acknowledge/pop of word on q)
//  q             out  WIDTH    read data
//  empty         out  1        no word readable
//  almost_empty  out  1        usedw <= AE_LVL
//  usedw         out  PTR+1    words held (0..DEPTH), incl. FWFT output stage
//  err_clr       in   1        clears sticky flags and counters (macro only)
//  overflow      out  1        sticky: write attempted while full
//  underflow     out  1        sticky: read attempted while empty
//  ovf_cnt       out  16       count of rejected writes, saturating at 16'hFFFF
//  unf_cnt       out  16       count of rejected reads, saturating at 16'hFFFF
// BEHAVIOUR
//  - Reset (srst=1 at edge): pointers=0, usedw=0, empty=1, full=0, almost_full=0,
//    almost_empty=1, q=0, overflow/underflow=0, counters=0. Requests in reset cycle ignored;
//    reset mid-traffic discards all contents, next accepted write lands at address 0.
//  - Write accepted iff wrreq & ~full; read accepted iff rdreq & ~empty. No bypass: write while
//    full is dropped even with a same-cycle read; read while empty is dropped even with a
//    same-cycle write.
//  - Pointers PTR bits, wrap DEPTH-1 -> 0 naturally. usedw registered: +1 write-only, -1
//    read-only, unchanged on simultaneous accepted write+read; update visible next cycle.
//  - full, almost_full, almost_empty registered, derived from next-state usedw (aligned with usedw).
//  - FWFT=0: empty deasserts 1 cycle after first write into empty FIFO; q updates 1 cycle after
//    an accepted read and holds otherwise.
//  - FWFT=1: 1-word output register prefetched from RAM; empty deasserts 2 cycles after write into
//    empty FIFO, q already valid that cycle; accepted rdreq pops, next word (if any) presented
//    next cycle with empty held low; empty asserts the cycle after last word popped.
//    Total capacity stays DEPTH (full from usedw).
//  - No X on q: RAM read only on valid address; q holds last value when idle.
// CONFIGURATION
//  - Macro BR_SYNC_FIFO_ERR_CNT_EN defined: overflow set cycle after wrreq&full, underflow set
//    cycle after rdreq&empty (empty as seen by consumer); ovf_cnt/unf_cnt +1 per event,
//    saturating; err_clr=1 clears all four next cycle (a same-cycle event is lost, clear wins).
//  - Macro not defined: error logic absent; overflow, underflow, ovf_cnt, unf_cnt tied 0; err_clr ignored.
// TESTING
//  - Reset then 1024 writes data=i, no reads -> full=1 after write 1024, usedw=1024, almost_full
//    from usedw=1020; 1025th write dropped (ovf_cnt=1 with macro).
//  - FWFT=0: write 0xAB_CDEF_0123 into empty, rdreq next cycle -> q=0xAB_CDEF_0123 cycle after
//    rdreq, empty=1, usedw=0.
//  - FWFT=1: single write 0x11 at cycle N -> empty=0 and q=0x11 at N+2 with no rdreq; rdreq pops -> empty=1.
//  - Full FIFO, simultaneous wrreq+rdreq -> read accepted, write dropped, usedw 1024->1023.
//  - 3000 random write/read cycles across pointer wrap -> q sequence matches model, usedw never >1024.
//  - 500 writes, assert srst one cycle mid-burst -> usedw=0, empty=1; next write/read returns that word.

Source files
------------

// File: rtl/br_sync_fifo_prm_if.sv
// ---------------------------------------------------------------------------
// br_sync_fifo_prm_if
//   Bundles the producer/consumer handshake, status and error-reporting
//   signals of the br_sync_fifo_prm single-clock FIFO into one interface.
//
//   Parameters
//     WIDTH : data word width in bits
//     PTR   : address width, FIFO depth is 2**PTR (usedw is PTR+1 bits)
//
//   Signals
//     wrreq, data            write request and write word (producer -> FIFO)
//     full, almost_full      write-side status (FIFO -> producer)
//     rdreq                  read request / pop acknowledge (consumer -> FIFO)
//     q                      read word (FIFO -> consumer)
//     empty, almost_empty    read-side status (FIFO -> consumer)
//     usedw                  number of words held, 0..2**PTR
//     err_clr                clears sticky error flags and counters
//     overflow, underflow    sticky error flags
//     ovf_cnt, unf_cnt       saturating rejected-write / rejected-read counts
//
//   Modports
//     master : the user side (drives requests, data and err_clr)
//     slave  : the FIFO side (drives data out, status and error reporting)
// ---------------------------------------------------------------------------
interface br_sync_fifo_prm_if #(
  parameter int WIDTH = 40,
  parameter int PTR   = 10
);

  logic             wrreq;
  logic [WIDTH-1:0] data;
  logic             full;
  logic             almost_full;
  logic             rdreq;
  logic [WIDTH-1:0] q;
  logic             empty;
  logic             almost_empty;
  logic [PTR:0]     usedw;
  logic             err_clr;
  logic             overflow;
  logic             underflow;
  logic [15:0]      ovf_cnt;
  logic [15:0]      unf_cnt;

  // User side: producer and consumer logic that talks to the FIFO.
  modport master (
    output wrreq, data, rdreq, err_clr,
    input  full, almost_full, q, empty, almost_empty, usedw,
           overflow, underflow, ovf_cnt, unf_cnt
  );

  // FIFO side.
  modport slave (
    input  wrreq, data, rdreq, err_clr,
    output full, almost_full, q, empty, almost_empty, usedw,
           overflow, underflow, ovf_cnt, unf_cnt
  );

endinterface

// File: rtl/br_sync_fifo_prm.sv
// ---------------------------------------------------------------------------
// br_sync_fifo_prm
//   Parametrised single-clock FIFO built on an inferred RAM. Buffers control
//   and descriptor words between LMAC core stages that share one clock.
//   Provides registered full / almost_full / almost_empty / usedw status,
//   a selectable first-word-fall-through read mode and optional sticky
//   error flags with saturating error counters.
//
//   Parameters
//     WIDTH  : data word width in bits
//     PTR    : RAM address width; DEPTH must equal 2**PTR
//     DEPTH  : capacity in words (power of two, >= 4)
//     AF_LVL : almost_full  asserted when usedw >= AF_LVL
//     AE_LVL : almost_empty asserted when usedw <= AE_LVL
//     FWFT   : 0 = standard read (q valid the cycle after an accepted rdreq)
//              1 = first-word-fall-through (head word already on q while
//                  empty is low, rdreq pops it)
//
//   Ports
//     clk  : clock, everything on the rising edge
//     srst : synchronous active-high reset; empties the FIFO, clears q,
//            status and error state
//     bus  : br_sync_fifo_prm_if slave modport carrying the write side
//            (wrreq, data, full, almost_full), the read side (rdreq, q,
//            empty, almost_empty), usedw and the error-reporting signals
//            (err_clr, overflow, underflow, ovf_cnt, unf_cnt)
//
//   Build option
//     BR_SYNC_FIFO_ERR_CNT_EN : when defined, overflow/underflow sticky flags
//     and ovf_cnt/unf_cnt saturating counters are built and err_clr clears
//     them. When undefined those outputs are tied to zero and err_clr is
//     ignored.
// ---------------------------------------------------------------------------
module br_sync_fifo_prm #(
  parameter int WIDTH  = 40,
  parameter int PTR    = 10,
  parameter int DEPTH  = 1024,
  parameter int AF_LVL = 1020,
  parameter int AE_LVL = 4,
  parameter int FWFT   = 0
) (
  input  logic              clk,
  input  logic              srst,
  br_sync_fifo_prm_if.slave bus
);

  localparam logic [PTR:0]   DEPTH_W = (PTR+1)'(DEPTH);
  localparam logic [PTR:0]   AF_W    = (PTR+1)'(AF_LVL);
  localparam logic [PTR:0]   AE_W    = (PTR+1)'(AE_LVL);
  localparam logic [PTR:0]   CNT_ONE = (PTR+1)'(1);
  localparam logic [PTR-1:0] PTR_ONE = PTR'(1);

  // Storage. Left unreset so synthesis can map it onto block RAM.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR-1:0]   rdPtr_q, rdPtr_d;
  logic [PTR:0]     usedw_q, usedw_d;
  logic             full_q, full_d;
  logic             almostFull_q, almostFull_d;
  logic             almostEmpty_q, almostEmpty_d;
  logic             empty_q, empty_d;
  logic [WIDTH-1:0] q_q;

  logic wrAcc;
  logic rdAcc;
  logic ramRd;

  // A write is taken only when there is room and a read only when the
  // consumer sees a word. Status comes from registers, so a same-cycle
  // read never makes room for a write into a full FIFO and a same-cycle
  // write never feeds a read from an empty one.
  assign wrAcc = bus.wrreq & ~full_q;
  assign rdAcc = bus.rdreq & ~empty_q;

  if (FWFT != 0) begin : gFwft
    // The q register acts as a one-word output stage and is counted in
    // usedw, so the RAM holds usedw minus that stage. A RAM word is
    // prefetched whenever the stage is empty or being popped this cycle.
    // empty then simply means "output stage not loaded".
    logic [PTR:0] ramCnt;
    assign ramCnt  = usedw_q - {{PTR{1'b0}}, ~empty_q};
    assign ramRd   = (ramCnt != '0) & (empty_q | rdAcc);
    assign empty_d = ~ramRd & (empty_q | rdAcc);
  end else begin : gStd
    // Standard mode: the RAM is read only for an accepted read, and the
    // FIFO is empty exactly when it holds no words.
    assign ramRd   = rdAcc;
    assign empty_d = (usedw_d == '0);
  end

  // Next-state for the pointers, the occupancy count and the level flags.
  // The flags are derived from the next occupancy so that, once registered,
  // they line up with the usedw value visible in the same cycle.
  always_comb begin
    usedw_d = usedw_q;
    case ({wrAcc, rdAcc})
      2'b10:   usedw_d = usedw_q + CNT_ONE;
      2'b01:   usedw_d = usedw_q - CNT_ONE;
      default: usedw_d = usedw_q;
    endcase

    wrPtr_d = wrPtr_q;
    if (wrAcc) begin
      wrPtr_d = wrPtr_q + PTR_ONE;
    end

    rdPtr_d = rdPtr_q;
    if (ramRd) begin
      rdPtr_d = rdPtr_q + PTR_ONE;
    end

    full_d        = (usedw_d == DEPTH_W);
    almostFull_d  = (usedw_d >= AF_W);
    almostEmpty_d = (usedw_d <= AE_W);
  end

  // Control state registers. Reset forgets all stored words, so the next
  // accepted write lands at address zero.
  always_ff @(posedge clk) begin
    if (srst) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      usedw_q       <= '0;
      full_q        <= 1'b0;
      almostFull_q  <= 1'b0;
      almostEmpty_q <= 1'b1;
      empty_q       <= 1'b1;
    end else begin
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      usedw_q       <= usedw_d;
      full_q        <= full_d;
      almostFull_q  <= almostFull_d;
      almostEmpty_q <= almostEmpty_d;
      empty_q       <= empty_d;
    end
  end

  // RAM write port. Requests during reset are ignored.
  always_ff @(posedge clk) begin
    if (wrAcc && !srst) begin
      mem[wrPtr_q] <= bus.data;
    end
  end

  // RAM read port with registered output. The RAM is only addressed when
  // the location holds a written word, so q never picks up undefined data;
  // between reads q keeps the last word delivered.
  always_ff @(posedge clk) begin
    if (srst) begin
      q_q <= '0;
    end else if (ramRd) begin
      q_q <= mem[rdPtr_q];
    end
  end

  assign bus.q            = q_q;
  assign bus.usedw        = usedw_q;
  assign bus.full         = full_q;
  assign bus.almost_full  = almostFull_q;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = almostEmpty_q;

`ifdef BR_SYNC_FIFO_ERR_CNT_EN

  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic [15:0] ovfCnt_q, ovfCnt_d;
  logic [15:0] unfCnt_q, unfCnt_d;
  logic        ovfEvt;
  logic        unfEvt;

  // An overflow is any write request against a full FIFO; an underflow is
  // any read request while the consumer sees empty (in FWFT mode that is
  // the output-stage empty, not the RAM occupancy).
  assign ovfEvt = bus.wrreq & full_q;
  assign unfEvt = bus.rdreq & empty_q;

  // Sticky flags and saturating counters. A clear takes priority over an
  // event in the same cycle, which is then not recorded.
  always_comb begin
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    ovfCnt_d = ovfCnt_q;
    unfCnt_d = unfCnt_q;
    if (bus.err_clr) begin
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      ovfCnt_d = '0;
      unfCnt_d = '0;
    end else begin
      if (ovfEvt) begin
        ovf_d = 1'b1;
        if (ovfCnt_q != 16'hFFFF) begin
          ovfCnt_d = ovfCnt_q + 16'd1;
        end
      end
      if (unfEvt) begin
        unf_d = 1'b1;
        if (unfCnt_q != 16'hFFFF) begin
          unfCnt_d = unfCnt_q + 16'd1;
        end
      end
    end
  end

  // Error state registers, cleared by reset like the rest of the FIFO.
  always_ff @(posedge clk) begin
    if (srst) begin
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      ovfCnt_q <= '0;
      unfCnt_q <= '0;
    end else begin
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      ovfCnt_q <= ovfCnt_d;
      unfCnt_q <= unfCnt_d;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.ovf_cnt   = ovfCnt_q;
  assign bus.unf_cnt   = unfCnt_q;

`else

  // Error reporting is not built: outputs are constant and err_clr has
  // no effect.
  logic errClrUnused;
  assign errClrUnused = bus.err_clr;

  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
  assign bus.ovf_cnt   = '0;
  assign bus.unf_cnt   = '0;

`endif

endmodule

// File: tb/tb_br_sync_fifo_prm.sv
// ---------------------------------------------------------------------------
// tb_br_sync_fifo_prm
//   Drives a standard-mode (FWFT=0) and a first-word-fall-through (FWFT=1)
//   instance of br_sync_fifo_prm with identical stimulus and compares every
//   output, every cycle, against a queue-based reference model.
//
//   Reference model
//     Each FIFO is a queue of words. Standard mode: empty when the queue is
//     empty, q shows the last word popped. FWFT mode: the head word becomes
//     visible two cycles after it was written and stays until popped; q
//     shows the visible head, or the last popped word when nothing is
//     visible. Error flags/counters are modelled when
//     BR_SYNC_FIFO_ERR_CNT_EN is defined, otherwise expected to stay zero.
// ---------------------------------------------------------------------------
module tb_br_sync_fifo_prm;

  localparam int WIDTH  = 40;
  localparam int PTR    = 10;
  localparam int DEPTH  = 1024;
  localparam int AF_LVL = 1020;
  localparam int AE_LVL = 4;

  logic clk = 1'b0;
  logic srst;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  br_sync_fifo_prm_if #(.WIDTH(WIDTH), .PTR(PTR)) bus0 ();
  br_sync_fifo_prm_if #(.WIDTH(WIDTH), .PTR(PTR)) bus1 ();

  br_sync_fifo_prm #(
    .WIDTH(WIDTH), .PTR(PTR), .DEPTH(DEPTH),
    .AF_LVL(AF_LVL), .AE_LVL(AE_LVL), .FWFT(0)
  ) dutStd (
    .clk (clk),
    .srst(srst),
    .bus (bus0)
  );

  br_sync_fifo_prm #(
    .WIDTH(WIDTH), .PTR(PTR), .DEPTH(DEPTH),
    .AF_LVL(AF_LVL), .AE_LVL(AE_LVL), .FWFT(1)
  ) dutFwft (
    .clk (clk),
    .srst(srst),
    .bus (bus1)
  );

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;

  logic [WIDTH-1:0] modelQ0 [$];
  logic [WIDTH-1:0] modelQ1 [$];
  int               modelT1 [$];
  logic [WIDTH-1:0] qHeld0   = '0;
  logic [WIDTH-1:0] lastPop1 = '0;
  logic             ovfM    [2] = '{1'b0, 1'b0};
  logic             unfM    [2] = '{1'b0, 1'b0};
  int               ovfCntM [2] = '{0, 0};
  int               unfCntM [2] = '{0, 0};

  // Single comparison point: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h",
               tag, cyc, observed, expected);
    end
  endtask

  // In FWFT mode the head word is on q once two clock edges have passed
  // since the cycle it was written.
  function automatic bit fwftVisible();
    return (modelQ1.size() > 0) && (modelT1[0] <= cyc - 2);
  endfunction

  // Compares every output of both FIFOs against the model state.
  task automatic compareAll();
    int n0;
    int n1;
    bit vis;
    n0  = modelQ0.size();
    n1  = modelQ1.size();
    vis = fwftVisible();
    checkOutput("std.usedw",        64'(bus0.usedw),        64'(n0));
    checkOutput("std.full",         64'(bus0.full),         64'(n0 == DEPTH));
    checkOutput("std.almost_full",  64'(bus0.almost_full),  64'(n0 >= AF_LVL));
    checkOutput("std.almost_empty", 64'(bus0.almost_empty), 64'(n0 <= AE_LVL));
    checkOutput("std.empty",        64'(bus0.empty),        64'(n0 == 0));
    checkOutput("std.q",            64'(bus0.q),            64'(qHeld0));
    checkOutput("fwft.usedw",        64'(bus1.usedw),        64'(n1));
    checkOutput("fwft.full",         64'(bus1.full),         64'(n1 == DEPTH));
    checkOutput("fwft.almost_full",  64'(bus1.almost_full),  64'(n1 >= AF_LVL));
    checkOutput("fwft.almost_empty", 64'(bus1.almost_empty), 64'(n1 <= AE_LVL));
    checkOutput("fwft.empty",        64'(bus1.empty),        64'(!vis));
    checkOutput("fwft.q",            64'(bus1.q),            64'(vis ? modelQ1[0] : lastPop1));
`ifdef BR_SYNC_FIFO_ERR_CNT_EN
    checkOutput("std.overflow",   64'(bus0.overflow),  64'(ovfM[0]));
    checkOutput("std.underflow",  64'(bus0.underflow), 64'(unfM[0]));
    checkOutput("std.ovf_cnt",    64'(bus0.ovf_cnt),   64'(ovfCntM[0]));
    checkOutput("std.unf_cnt",    64'(bus0.unf_cnt),   64'(unfCntM[0]));
    checkOutput("fwft.overflow",  64'(bus1.overflow),  64'(ovfM[1]));
    checkOutput("fwft.underflow", 64'(bus1.underflow), 64'(unfM[1]));
    checkOutput("fwft.ovf_cnt",   64'(bus1.ovf_cnt),   64'(ovfCntM[1]));
    checkOutput("fwft.unf_cnt",   64'(bus1.unf_cnt),   64'(unfCntM[1]));
`else
    checkOutput("std.overflow",   64'(bus0.overflow),  64'(0));
    checkOutput("std.underflow",  64'(bus0.underflow), 64'(0));
    checkOutput("std.ovf_cnt",    64'(bus0.ovf_cnt),   64'(0));
    checkOutput("std.unf_cnt",    64'(bus0.unf_cnt),   64'(0));
    checkOutput("fwft.overflow",  64'(bus1.overflow),  64'(0));
    checkOutput("fwft.underflow", 64'(bus1.underflow), 64'(0));
    checkOutput("fwft.ovf_cnt",   64'(bus1.ovf_cnt),   64'(0));
    checkOutput("fwft.unf_cnt",   64'(bus1.unf_cnt),   64'(0));
`endif
  endtask

  // Error bookkeeping for one FIFO: clear wins over a same-cycle event.
  task automatic errorModel(input int k, input bit ovfEvt, input bit unfEvt,
                            input bit clr);
    if (clr) begin
      ovfM[k] = 1'b0;  unfM[k] = 1'b0;
      ovfCntM[k] = 0;  unfCntM[k] = 0;
    end else begin
      if (ovfEvt) begin
        ovfM[k] = 1'b1;
        if (ovfCntM[k] < 65535) ovfCntM[k]++;
      end
      if (unfEvt) begin
        unfM[k] = 1'b1;
        if (unfCntM[k] < 65535) unfCntM[k]++;
      end
    end
  endtask

  // Advances the model by one clock edge using this cycle's inputs.
  task automatic updateModel(input bit wr, input bit rd, input bit rst,
                             input bit clr, input logic [WIDTH-1:0] d);
    bit full0, empty0, full1, empty1;
    if (rst) begin
      modelQ0.delete();
      modelQ1.delete();
      modelT1.delete();
      qHeld0   = '0;
      lastPop1 = '0;
      for (int k = 0; k < 2; k++) begin
        ovfM[k] = 1'b0;  unfM[k] = 1'b0;
        ovfCntM[k] = 0;  unfCntM[k] = 0;
      end
    end else begin
      full0  = (modelQ0.size() == DEPTH);
      empty0 = (modelQ0.size() == 0);
      full1  = (modelQ1.size() == DEPTH);
      empty1 = !fwftVisible();
      if (rd && !empty0) qHeld0 = modelQ0.pop_front();
      if (wr && !full0)  modelQ0.push_back(d);
      if (rd && !empty1) begin
        lastPop1 = modelQ1.pop_front();
        void'(modelT1.pop_front());
      end
      if (wr && !full1) begin
        modelQ1.push_back(d);
        modelT1.push_back(cyc);
      end
      errorModel(0, wr && full0, rd && empty0, clr);
      errorModel(1, wr && full1, rd && empty1, clr);
    end
  endtask

  // One bench cycle: check outputs at the falling edge, then drive the
  // next inputs into both FIFOs and step the model.
  task automatic applyStimulus(input bit wr, input bit rd, input bit rst,
                               input bit clr, input logic [WIDTH-1:0] d);
    @(negedge clk);
    cyc++;
    compareAll();
    srst         = rst;
    bus0.wrreq   = wr;   bus1.wrreq   = wr;
    bus0.rdreq   = rd;   bus1.rdreq   = rd;
    bus0.err_clr = clr;  bus1.err_clr = clr;
    bus0.data    = d;    bus1.data    = d;
    updateModel(wr, rd, rst, clr, d);
  endtask

  // Test sequence: reset, fill to full and beyond, full with simultaneous
  // read/write, drain past empty, single-word latency checks, randomized
  // traffic across pointer wrap, and reset in the middle of a burst.
  initial begin
    logic [WIDTH-1:0] rnd;
    bit wr, rd, clr;

    srst = 1'b1;
    bus0.wrreq = 1'b0;  bus1.wrreq = 1'b0;
    bus0.rdreq = 1'b0;  bus1.rdreq = 1'b0;
    bus0.err_clr = 1'b0;  bus1.err_clr = 1'b0;
    bus0.data = '0;  bus1.data = '0;
    repeat (2) @(posedge clk);

    applyStimulus(0, 0, 1, 0, '0);
    applyStimulus(0, 0, 0, 0, '0);

    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(1, 0, 0, 0, WIDTH'(i));
    end

    applyStimulus(1, 1, 0, 0, 40'hDE_ADBE_EF00);

    for (int i = 0; i < DEPTH + 6; i++) begin
      applyStimulus(0, 1, 0, 0, '0);
    end

    applyStimulus(0, 0, 1, 0, '0);
    applyStimulus(1, 0, 0, 0, 40'hAB_CDEF_0123);
    applyStimulus(0, 1, 0, 0, '0);
    repeat (3) applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(0, 1, 0, 0, '0);
    repeat (3) applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(1, 0, 0, 0, 40'h00_0000_0011);
    repeat (3) applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(0, 1, 0, 0, '0);
    applyStimulus(0, 0, 0, 1, '0);

    for (int i = 0; i < 3000; i++) begin
      if (i < 1500) begin
        wr = ($urandom_range(0, 99) < 70);
        rd = ($urandom_range(0, 99) < 40);
      end else begin
        wr = ($urandom_range(0, 99) < 35);
        rd = ($urandom_range(0, 99) < 70);
      end
      clr = ($urandom_range(0, 63) == 0);
      rnd = {8'($urandom), 32'($urandom)};
      applyStimulus(wr, rd, 0, clr, rnd);
    end

    for (int i = 0; i < 500; i++) begin
      applyStimulus(1, 0, (i == 250), 0, WIDTH'(32'h1000 + i));
    end
    applyStimulus(0, 0, 1, 0, '0);
    repeat (2) applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(1, 0, 0, 0, 40'h5A_5A5A_5A5A);
    repeat (2) applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(0, 1, 0, 0, '0);
    repeat (3) applyStimulus(0, 0, 0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
